echo_generator_lag16: RTL



---
 rtl/echo_generator_lag16_if.sv | 31 +++
 rtl/echo_generator_lag16.sv | 124 ++++++++++++
 2 files changed

// File: rtl/echo_generator_lag16_if.sv
// Bus bundle for the 16-tap echo-path model: framing/sample inputs, coefficient
// port, and the echoed-sample result with status strobes.
interface echo_generator_lag16_if;
    logic               enable;
    logic [12:0]        sampling_cycle_counter;
    logic signed [15:0] sig16b;
    logic signed [15:0] near16b;
    logic               coef_wr;
    logic [3:0]         coef_addr;
    logic signed [15:0] coef_data;
    logic signed [15:0] sig16b_lag;
    logic               ready;
    logic               busy;
    logic               sat_flag;
    logic               coef_err;
    logic [1:0]         dbg_state;

    // ready is a one-cycle valid strobe for sig16b_lag/sat_flag; there is no
    // backpressure, the consumer must take the sample in that cycle.
    modport master (
        output enable, sampling_cycle_counter, sig16b, near16b,
        output coef_wr, coef_addr, coef_data,
        input  sig16b_lag, ready, busy, sat_flag, coef_err, dbg_state
    );

    modport slave (
        input  enable, sampling_cycle_counter, sig16b, near16b,
        input  coef_wr, coef_addr, coef_data,
        output sig16b_lag, ready, busy, sat_flag, coef_err, dbg_state
    );
endinterface

// File: rtl/echo_generator_lag16.sv
// Sequential 16-tap echo-path model: one MAC per cycle over a 16-sample far-end
// history, plus the near-end sample, rounded and saturated to 16 bits.
module echo_generator_lag16 #(
    parameter int TAPS   = 16,
    parameter int COEF_W = 16
) (
    input logic                    clk_operation,
    input logic                    rst,
    echo_generator_lag16_if.slave  io_bus
);
    localparam int ACC_W = 38;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_next_state;
    logic signed [15:0]        r_hist [TAPS];
    logic signed [COEF_W-1:0]  r_coef [TAPS];
    logic signed [ACC_W-1:0]   r_acc;
    logic [3:0]                r_k;
    logic signed [15:0]        r_lag;
    logic                      r_ready;
    logic                      r_sat;
    logic                      r_coef_err;

    logic                      w_busy;
    logic                      w_trigger;
    logic signed [31:0]        w_prod;
    logic signed [ACC_W-1:0]   w_near_acc;
    logic signed [ACC_W-1:0]   w_rounded;
    logic signed [ACC_W-1:0]   w_shifted;
    logic signed [15:0]        w_sat_val;
    logic                      w_sat_hit;

    assign w_busy     = (r_state != ST_IDLE);
    assign w_trigger  = (r_state == ST_IDLE) && io_bus.enable &&
                        (io_bus.sampling_cycle_counter == 13'd0);
    assign w_prod     = 32'(r_coef[r_k]) * 32'(r_hist[r_k]);
    assign w_near_acc = {{7{io_bus.near16b[15]}}, io_bus.near16b, 15'd0};
    // Round half up, then drop the Q15 fraction.
    assign w_rounded  = r_acc + 38'sd16384;
    assign w_shifted  = w_rounded >>> 15;

    always_comb begin
        w_sat_val = w_shifted[15:0];
        w_sat_hit = 1'b0;
        if (w_shifted > 38'sd32767) begin
            w_sat_val = 16'sh7FFF;
            w_sat_hit = 1'b1;
        end else if (w_shifted < -38'sd32768) begin
            w_sat_val = 16'sh8000;
            w_sat_hit = 1'b1;
        end
    end

    always_ff @(posedge clk_operation) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_trigger)     w_next_state = ST_MAC;
            ST_MAC:  if (r_k == 4'd15)  w_next_state = ST_OUT;
            ST_OUT:                     w_next_state = ST_IDLE;
            default:                    w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_operation) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) begin
                r_hist[i] <= '0;
                r_coef[i] <= '0;
            end
            r_acc      <= '0;
            r_k        <= '0;
            r_lag      <= '0;
            r_ready    <= 1'b0;
            r_sat      <= 1'b0;
            r_coef_err <= 1'b0;
        end else begin
            r_ready    <= 1'b0;
            // Writes are only safe while no MAC is reading the table.
            r_coef_err <= io_bus.coef_wr && w_busy;
            if (io_bus.coef_wr && !w_busy)
                r_coef[io_bus.coef_addr] <= io_bus.coef_data;

            case (r_state)
                ST_IDLE: begin
                    if (w_trigger) begin
                        r_hist[0] <= io_bus.sig16b;
                        for (int i = 1; i < TAPS; i++)
                            r_hist[i] <= r_hist[i-1];
                        r_acc <= w_near_acc;
                        r_k   <= 4'd0;
                    end
                end
                ST_MAC: begin
                    r_acc <= r_acc + {{(ACC_W-32){w_prod[31]}}, w_prod};
                    r_k   <= r_k + 4'd1;
                end
                ST_OUT: begin
                    r_lag   <= w_sat_val;
                    r_sat   <= w_sat_hit;
                    r_ready <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign io_bus.sig16b_lag = r_lag;
    assign io_bus.ready      = r_ready;
    assign io_bus.busy       = w_busy;
    assign io_bus.sat_flag   = r_sat;
    assign io_bus.coef_err   = r_coef_err;
    assign io_bus.dbg_state  = r_state;
endmodule
